// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared load/store size encodings, LSU state type and access helpers
package riscv_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_BUSY,
        LSU_DONE
    } lsu_state_t;

    // Unsigned sizes only make sense for loads; stores must be B, H or W.
    function automatic logic lsu_legal(input logic we, input logic [2:0] size,
                                       input logic [1:0] off);
        case (size)
            LDST_B:  lsu_legal = 1'b1;
            LDST_BU: lsu_legal = !we;
            LDST_H:  lsu_legal = !off[0];
            LDST_HU: lsu_legal = !we && !off[0];
            LDST_W:  lsu_legal = (off == 2'b00);
            default: lsu_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lsu_be(input logic [2:0] size, input logic [1:0] off);
        case (size)
            LDST_B, LDST_BU: lsu_be = 4'b0001 << off;
            LDST_H, LDST_HU: lsu_be = off[1] ? 4'b1100 : 4'b0011;
            default:         lsu_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lsu_wdata(input logic [2:0] size, input logic [31:0] wd);
        case (size)
            LDST_B:  lsu_wdata = {4{wd[7:0]}};
            LDST_H:  lsu_wdata = {2{wd[15:0]}};
            default: lsu_wdata = wd;
        endcase
    endfunction

endpackage

// File: rtl/riscv_lsu_extend.sv
// rtl/riscv_lsu_extend.sv - selects and sign/zero-extends the loaded byte/half/word
module riscv_lsu_extend
    import riscv_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  size,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? word[31:16] : word[15:0];
        case (size)
            LDST_B:  result = {{24{byte_sel[7]}}, byte_sel};
            LDST_BU: result = {24'd0, byte_sel};
            LDST_H:  result = {{16{half_sel[15]}}, half_sel};
            LDST_HU: result = {16'd0, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - load/store unit bridging the decoder to a word-organised data memory
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_misaligned_o,
    output logic        core_bus_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    lsu_state_t  state;
    logic [CW-1:0] cnt;
    logic        we_q;
    logic [2:0]  size_q;
    logic [1:0]  off_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wd_q;
    logic        bus_err_q;
    logic [31:0] rd_q;
    logic [31:0] ext_data;
    logic        legal;
    logic        timeout;

    riscv_lsu_extend u_extend (
        .word   (mem_rd_i),
        .offset (off_q),
        .size   (size_q),
        .result (ext_data)
    );

    assign legal   = lsu_legal(core_we_i, core_size_i, core_addr_i[1:0]);
    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= LSU_IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            size_q    <= 3'd0;
            off_q     <= 2'd0;
            addr_q    <= 32'd0;
            be_q      <= 4'd0;
            wd_q      <= 32'd0;
            bus_err_q <= 1'b0;
            rd_q      <= 32'd0;
        end else begin
            bus_err_q <= 1'b0;
            case (state)
                LSU_IDLE: begin
                    if (core_req_i && legal) begin
                        state  <= LSU_BUSY;
                        cnt    <= '0;
                        we_q   <= core_we_i;
                        size_q <= core_size_i;
                        off_q  <= core_addr_i[1:0];
                        addr_q <= {core_addr_i[31:2], 2'b00};
                        be_q   <= lsu_be(core_size_i, core_addr_i[1:0]);
                        wd_q   <= lsu_wdata(core_size_i, core_wd_i);
                    end
                end
                LSU_BUSY: begin
                    // Ready takes priority over a timeout landing in the same cycle.
                    if (mem_ready_i) begin
                        if (!we_q) rd_q <= ext_data;
                        state <= LSU_DONE;
                        cnt   <= '0;
                    end else if (timeout) begin
                        bus_err_q <= 1'b1;
                        state     <= LSU_DONE;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LSU_DONE: state <= LSU_IDLE;
                default:  state <= LSU_IDLE;
            endcase
        end
    end

    // Request tracks the state register directly so an async reset drops it at once.
    assign mem_req_o         = (state == LSU_BUSY);
    assign mem_we_o          = mem_req_o & we_q;
    assign mem_be_o          = mem_req_o ? be_q : 4'd0;
    assign mem_addr_o        = addr_q;
    assign mem_wd_o          = wd_q;
    assign core_rd_o         = rd_q;
    assign core_bus_err_o    = bus_err_q;
    assign core_stall_o      = (state == LSU_BUSY) || ((state == LSU_IDLE) && core_req_i && legal);
    assign core_misaligned_o = (state == LSU_IDLE) && core_req_i && !legal;

endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - directed and randomized self-checking bench for riscv_lsu
module tb_riscv_lsu;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        core_req_i = 1'b0;
    logic        core_we_i = 1'b0;
    logic [2:0]  core_size_i = 3'd0;
    logic [31:0] core_addr_i = 32'd0;
    logic [31:0] core_wd_i = 32'd0;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        core_misaligned_o;
    logic        core_bus_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i = 32'd0;
    logic        mem_ready_i = 1'b0;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_rd = 32'd0;

    riscv_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .core_req_i        (core_req_i),
        .core_we_i         (core_we_i),
        .core_size_i       (core_size_i),
        .core_addr_i       (core_addr_i),
        .core_wd_i         (core_wd_i),
        .core_rd_o         (core_rd_o),
        .core_stall_o      (core_stall_o),
        .core_misaligned_o (core_misaligned_o),
        .core_bus_err_o    (core_bus_err_o),
        .mem_req_o         (mem_req_o),
        .mem_we_o          (mem_we_o),
        .mem_be_o          (mem_be_o),
        .mem_addr_o        (mem_addr_o),
        .mem_wd_o          (mem_wd_o),
        .mem_rd_i          (mem_rd_i),
        .mem_ready_i       (mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] size);
        case (size)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic legal_ref(input logic we, input logic [2:0] size, input logic [31:0] addr);
        int nb;
        nb = nbytes(size);
        if (nb == 0) return 1'b0;
        if (we && size[2]) return 1'b0;
        return (addr % nb) == 0;
    endfunction

    function automatic logic [31:0] load_ref(input logic [2:0] size, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int nb;
        logic [31:0] v;
        nb = nbytes(size);
        if (nb == 4) return rdata;
        v = (rdata >> (8 * addr[1:0])) & ((32'd1 << (8 * nb)) - 32'd1);
        if (!size[2] && v >= (32'd1 << (8 * nb - 1))) v = v - (32'd1 << (8 * nb));
        return v;
    endfunction

    task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rdata, input int delay);
        int nb;
        int n;
        logic ok;
        logic timed_out;
        logic [31:0] be;
        logic [31:0] wexp;
        nb = nbytes(size);
        ok = legal_ref(we, size, addr);
        @(posedge clk_i); #1;
        core_req_i = 1'b1; core_we_i = we; core_size_i = size;
        core_addr_i = addr; core_wd_i = wd; mem_ready_i = 1'b0;
        @(negedge clk_i);
        chk("misaligned", {31'd0, core_misaligned_o}, {31'd0, !ok});
        chk("stall_at_req", {31'd0, core_stall_o}, {31'd0, ok});
        chk("req_in_idle", {31'd0, mem_req_o}, 32'd0);
        @(posedge clk_i); #1;
        core_req_i = 1'b0;
        if (!ok) begin
            @(negedge clk_i);
            chk("req_after_illegal", {31'd0, mem_req_o}, 32'd0);
            chk("stall_after_illegal", {31'd0, core_stall_o}, 32'd0);
            return;
        end
        be   = ((32'd1 << nb) - 32'd1) << addr[1:0];
        wexp = (nb == 1) ? wd[7:0] * 32'h0101_0101 : (nb == 2) ? wd[15:0] * 32'h0001_0001 : wd;
        n = 0;
        timed_out = 1'b0;
        forever begin
            mem_ready_i = (n >= delay);
            mem_rd_i    = mem_ready_i ? rdata : $urandom;
            @(negedge clk_i);
            chk("busy_req", {31'd0, mem_req_o}, 32'd1);
            chk("busy_stall", {31'd0, core_stall_o}, 32'd1);
            chk("busy_we", {31'd0, mem_we_o}, {31'd0, we});
            chk("busy_be", {28'd0, mem_be_o}, be);
            chk("busy_addr", mem_addr_o, addr & 32'hFFFF_FFFC);
            if (we) chk("busy_wd", mem_wd_o, wexp);
            if (mem_ready_i) break;
            if (n == TO - 1) begin
                timed_out = 1'b1;
                break;
            end
            @(posedge clk_i); #1;
            n++;
        end
        @(posedge clk_i); #1;
        mem_ready_i = 1'b0;
        if (!we && !timed_out) exp_rd = load_ref(size, addr, rdata);
        // A request raised during the retiring cycle must not start an access.
        core_req_i  = $urandom_range(0, 1);
        core_we_i   = 1'b0; core_size_i = 3'd2; core_addr_i = 32'h40;
        @(negedge clk_i);
        chk("done_stall", {31'd0, core_stall_o}, 32'd0);
        chk("done_req", {31'd0, mem_req_o}, 32'd0);
        chk("done_bus_err", {31'd0, core_bus_err_o}, {31'd0, timed_out});
        chk("done_rd", core_rd_o, exp_rd);
        @(posedge clk_i); #1;
        core_req_i = 1'b0;
        @(negedge clk_i);
        chk("idle_stall", {31'd0, core_stall_o}, 32'd0);
        chk("idle_bus_err", {31'd0, core_bus_err_o}, 32'd0);
        chk("idle_req", {31'd0, mem_req_o}, 32'd0);
    endtask

    initial begin
        #12;
        chk("rst_stall", {31'd0, core_stall_o}, 32'd0);
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_rd", core_rd_o, 32'd0);
        chk("rst_bus_err", {31'd0, core_bus_err_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        access(1'b0, 3'd0, 32'h103, 32'd0, 32'h80FF_0000, 0);
        chk("lb_result", core_rd_o, 32'hFFFF_FF80);
        access(1'b0, 3'd5, 32'h202, 32'd0, 32'hBEEF_1234, 1);
        chk("lhu_result", core_rd_o, 32'h0000_BEEF);
        access(1'b0, 3'd1, 32'h202, 32'd0, 32'hBEEF_1234, 2);
        chk("lh_result", core_rd_o, 32'hFFFF_BEEF);
        access(1'b1, 3'd0, 32'h1, 32'h1234_56AB, 32'h5555_5555, 0);
        chk("sb_keeps_rd", core_rd_o, 32'hFFFF_BEEF);
        access(1'b0, 3'd2, 32'h2, 32'd0, 32'd0, 0);
        access(1'b0, 3'd3, 32'h0, 32'd0, 32'd0, 0);
        access(1'b1, 3'd4, 32'h0, 32'd0, 32'd0, 0);
        access(1'b1, 3'd2, 32'h80, 32'hCAFE_F00D, 32'd0, 100);
        access(1'b0, 3'd2, 32'h84, 32'd0, 32'h1357_9BDF, TO - 1);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            access(1'(($urandom_range(0, 2) == 0)), 3'($urandom_range(0, 7)), a,
                   $urandom, $urandom, $urandom_range(0, 5));
        end

        @(posedge clk_i); #1;
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2; core_addr_i = 32'h10;
        @(posedge clk_i); #1;
        core_req_i = 1'b0;
        @(negedge clk_i);
        chk("pre_reset_busy", {31'd0, mem_req_o}, 32'd1);
        #1 rst_ni = 1'b0;
        #1;
        chk("async_rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("async_rst_stall", {31'd0, core_stall_o}, 32'd0);
        chk("async_rst_rd", core_rd_o, 32'd0);
        exp_rd = 32'd0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        access(1'b0, 3'd2, 32'h0, 32'd0, 32'hA5A5_0F0F, 1);
        chk("lw_after_reset", core_rd_o, 32'hA5A5_0F0F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
